// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small show-ahead receive FIFO.
// Two-flop input synchronizer, down-counter bit timing, and a valid/ready read port.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | line idle, waiting for a synchronized falling edge
// S_START     | half-bit wait, then confirm the start bit is still low
// S_DATA      | sampling 8 data bits, LSB first, at mid-bit
// S_STOP      | sampling the stop bit; high pushes the byte, low flags it
// S_WAIT_HIGH | bad stop bit seen; hold until the line returns high
module uart_rx_fifo #(
  parameter int BIT_CYCLES = 3333,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] C_FULL  = CW'(BIT_CYCLES);
  localparam logic [CW-1:0] C_HALF  = CW'(BIT_CYCLES / 2);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [NW-1:0] C_DEPTH = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic          r_rx_meta;
  logic          r_rx_s;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          w_expire;
  logic          w_push;
  logic          w_ferr;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [NW-1:0] r_count;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          r_frame_err;
  logic          r_overrun;

  // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_in;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // The timer expires on the cycle it reads 1, so a load of N samples N edges later.
  assign w_expire = (r_cnt == C_ONE);

  // Next-state, timer reload and byte assembly; push/frame-error strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = C_HALF;
        end
      end
      S_START: begin
        if (w_expire) begin
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = C_FULL;
            w_idx_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_DATA: begin
        if (w_expire) begin
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_cnt_nxt   = C_FULL;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_STOP: begin
        if (w_expire) begin
          if (r_rx_s) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_WAIT_HIGH: begin
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_full = (r_count == C_DEPTH);
  assign w_pop  = rx_valid && rx_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_wr   = w_push && (!w_full || w_pop);

  // FIFO storage; contents need no reset because the read port is gated by count.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Single-cycle status pulses; push and frame error are exclusive, so these never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_push && w_full && !w_pop;
    end
  end

  assign rx_valid  = (r_count != '0);
  assign rx_data   = rx_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_fifo;

  localparam int BC       = 16;
  localparam int FD       = 4;
  // Negedge index (from the start-bit drive) at which the mid-stop push becomes visible:
  // 2 sync edges + 1 detect edge + BC/2 + 9*BC.
  localparam int STOP_SMP = BC / 2 + 9 * BC + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int n_cmp    = 0;
  int n_bad    = 0;
  int ferr_cnt = 0;
  int ov_cnt   = 0;
  int both_cnt = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [7];

  uart_rx_fifo #(.BIT_CYCLES(BC), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // Pulse and busy-cycle counters, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (frame_err) ferr_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
    if (rx_busy) busy_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, rx_valid, 1'b1);
    chk({name, "_data"}, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // One 8N1 frame, one bit every BC negedges; leaves rx_in at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic exp_ferr,
                            input logic exp_ov, input logic pop_at_stop, input int rst_at,
                            input logic chk_v);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10 * BC; i++) begin
      @(negedge clk);
      rx_in = bits[i / BC];
      if (rst_at >= 0 && i == rst_at) begin
        chk("busy_before_rst", rx_busy, 1'b1);
        reset = 1'b1;
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk("rst_mid_valid", rx_valid, 1'b0);
        chk("rst_mid_data", rx_data, 8'h00);
        chk("rst_mid_busy", rx_busy, 1'b0);
        chk("rst_mid_ferr", frame_err, 1'b0);
        chk("rst_mid_ov", overrun, 1'b0);
        reset = 1'b0;
      end
      if (chk_v && i == STOP_SMP - 1) chk("valid_before_push", rx_valid, 1'b0);
      if (chk_v && i == STOP_SMP) begin
        chk("valid_after_push", rx_valid, 1'b1);
        chk("data_after_push", rx_data, d);
      end
      if (pop_at_stop && i == STOP_SMP - 1) rx_ready = 1'b1;
      if (i == STOP_SMP) begin
        chk("stop_ferr", frame_err, exp_ferr);
        chk("stop_ov", overrun, exp_ov);
        if (pop_at_stop) rx_ready = 1'b0;
      end
    end
  endtask

  initial begin
    int b0;
    int f0;
    int o0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{8'h5A, 1'b0, 1'b0, 8'h00, 1'b1};

    rx_in    = 1'b1;
    rx_ready = 1'b0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ov", overrun, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    reset = 1'b0;
    idle(5);

    // Single frame with push latency check, then pop.
    f0 = ferr_cnt;
    o0 = ov_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    idle(10);
    pop_chk("t1_pop", 8'hA5);
    chk("t1_valid_drop", rx_valid, 1'b0);
    chk("t1_ferr_cnt", ferr_cnt - f0, 0);
    chk("t1_ov_cnt", ov_cnt - o0, 0);

    // Short low glitch on the line is rejected at mid start bit.
    b0 = busy_cnt;
    f0 = ferr_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    idle(40);
    chk("t2_busy_seen", (busy_cnt - b0) >= 1, 1'b1);
    chk("t2_busy_short", (busy_cnt - b0) <= 11, 1'b1);
    chk("t2_busy_now", rx_busy, 1'b0);
    chk("t2_valid", rx_valid, 1'b0);
    chk("t2_ferr_cnt", ferr_cnt - f0, 0);

    // Bad stop bit followed by a break: one frame error, then recovery.
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    chk("t3_busy_in_break", rx_busy, 1'b1);
    idle(20);
    chk("t3_ferr_once", ferr_cnt - f0, 1);
    chk("t3_valid", rx_valid, 1'b0);
    chk("t3_busy_after", rx_busy, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    idle(10);
    pop_chk("t3_pop", 8'h7E);
    chk("t3_empty", rx_valid, 1'b0);

    // Table of single frames: data patterns and stop-bit errors.
    for (int k = 0; k < 7; k++) begin
      send_frame(vecs[k].d, vecs[k].stop, vecs[k].exp_ferr, 1'b0, 1'b0, -1, 1'b0);
      idle(40);
      chk($sformatf("vec%0d_valid", k), rx_valid, vecs[k].exp_valid);
      if (vecs[k].exp_valid) begin
        pop_chk($sformatf("vec%0d_pop", k), vecs[k].exp_data);
        chk($sformatf("vec%0d_empty", k), rx_valid, 1'b0);
      end
    end

    // Five back-to-back frames into a 4-deep FIFO: one overrun, first four kept.
    o0 = ov_cnt;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, 1'b0, (k == 5), 1'b0, -1, 1'b0);
    end
    idle(10);
    chk("t4_ov_cnt", ov_cnt - o0, 1);
    for (int k = 1; k <= 4; k++) begin
      pop_chk($sformatf("t4_pop%0d", k), 8'(k));
    end
    chk("t4_empty", rx_valid, 1'b0);

    // Full FIFO with a pop on the exact push edge: no overrun, new byte kept.
    o0 = ov_cnt;
    for (int k = 1; k <= 4; k++) begin
      send_frame(8'(k), 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    end
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(10);
    chk("t5_ov_cnt", ov_cnt - o0, 0);
    pop_chk("t5_pop02", 8'h02);
    pop_chk("t5_pop03", 8'h03);
    pop_chk("t5_pop04", 8'h04);
    pop_chk("t5_pop55", 8'h55);
    chk("t5_empty", rx_valid, 1'b0);

    // Reset in the middle of data bit 4 clears the FIFO and aborts the frame.
    send_frame(8'h99, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    idle(10);
    chk("t6_pre_valid", rx_valid, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 4 * BC + BC + BC / 2, 1'b0);
    idle(40);
    chk("t6_no_byte", rx_valid, 1'b0);
    chk("t6_idle", rx_busy, 1'b0);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    idle(10);
    pop_chk("t6_pop", 8'h12);
    chk("t6_empty", rx_valid, 1'b0);

    chk("flags_never_coincide", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver that consumes the serial `txd` line driven by the MicroBlaze MCS top-level.
- Converts 8N1 frames into bytes and buffers them in a small show-ahead FIFO with a valid/ready read port.
- Sits downstream of the MCS UART, either in the board-level loopback/monitor path or as the capture stage of the system bench.
- Runs on the 32 MHz board clock.

Parameters:
- BIT_CYCLES, 3333, clock cycles per bit period (32 MHz / 9600 baud); legal range ≥ 8.
- FIFO_DEPTH, 4, byte entries in the receive FIFO; power of two, 2..16.

Ports:
- clk  input  1  system clock, 32 MHz, rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line, idle high.
- rx_data  output  8  head-of-FIFO byte; meaningful only while rx_valid=1.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts the head byte when rx_valid && rx_ready at a rising edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed byte dropped because the FIFO was full.
- rx_busy  output  1  high from start-bit detect until return to IDLE.

Behaviour:
- **Reset**
  - One clock and one reset. Reset is synchronous and active-high.
  - While reset=1 at a clock edge: FSM goes to IDLE, counters clear, FIFO pointers clear.
  - Synchronizer flops load 1.
  - Outputs: rx_valid=0, rx_data=8'h00, frame_err=0, overrun=0, rx_busy=0.
  - Reset mid-frame aborts the frame; no partial byte is written.
- **Input synchronizer**
  - rx_in passes through 2 flops (rx_s). All decisions use rx_s, so there is 2 cycles of latency.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE**
  - rx_s=0 → START; bit counter loads BIT_CYCLES/2 (integer division); rx_busy=1.
- **START**
  - When the counter expires (mid start bit), sample rx_s.
  - rx_s=1 → glitch: go to IDLE, no flags, rx_busy=0.
  - rx_s=0 → DATA; counter reloads BIT_CYCLES; bit index=0.
- **DATA**
  - At each expiry, shift rx_s into the shift register, LSB first.
  - After bit index 7 → STOP with counter reload.
- **STOP**
  - At expiry, sample rx_s.
  - rx_s=1: byte is complete → push to FIFO, then IDLE.
  - rx_s=0: frame_err pulses for 1 cycle, byte discarded, go to WAIT_HIGH.
- **WAIT_HIGH**
  - Remain until rx_s=1, then IDLE. This covers a break condition, which produces one frame_err only.
- **Timing**
  - Sample points fall at BIT_CYCLES/2 + n·BIT_CYCLES cycles after the synchronized falling edge, n = 0..9.
  - The counter counts down, and expiry is the cycle it reads 1.
- **FIFO**
  - Registered, show-ahead. A push is visible on rx_valid/rx_data the cycle after the push edge.
  - Pop occurs on rx_valid && rx_ready.
  - Push while full and no pop: overrun pulses 1 cycle, the new byte is dropped, and contents are unchanged.
  - Push and pop in the same cycle when full: both happen, no overrun, count unchanged.
  - Push and pop in the same cycle when count=1: rx_valid stays 1 and rx_data advances to the new byte.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
  - rx_ready while empty has no effect.
- **Flag coincidence**
  - frame_err and overrun are never asserted in the same cycle.
  - The FSM continues receiving regardless of FIFO state.

Test Plan:
Bench uses BIT_CYCLES=16 and FIFO_DEPTH=4, with rx_ready held 0 unless stated.
1. Single frame 8'hA5 sent at 16 cycles/bit, then rx_ready=1 → rx_valid rises 1 cycle after the mid-stop sample with rx_data=8'hA5; rx_valid drops the cycle after the pop; frame_err=0, overrun=0.
2. rx_in pulsed low for 4 cycles, then held high → rx_busy high for ≤ 11 cycles; no FIFO write, no flags; FSM back to IDLE.
3. Frame 8'h3C with stop bit forced low, line held low for 40 cycles, then high → exactly one frame_err pulse; rx_valid stays 0; next frame 8'h7E received correctly.
4. Five back-to-back frames 8'h01..8'h05 with rx_ready=0 → FIFO holds 01..04; overrun pulses once at the 5th mid-stop sample; then popping with rx_ready=1 yields 01, 02, 03, 04, then rx_valid=0.
5. FIFO full (01..04) and rx_ready=1 held on the exact cycle the 5th byte 8'h55 completes → no overrun; subsequent reads return 02, 03, 04, 55.
6. Reset asserted for 1 cycle in the middle of data bit 4 of frame 8'hFF → all outputs at reset values the next cycle; the remainder of that frame produces no byte; a following frame 8'h12 is received correctly.
